// File: rtl/pcileech_sysctl_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pcileech_sysctl_seq_if : button inputs and sequenced reset outputs. Rev 1.0
// ----------------------------------------------------------------------------
interface pcileech_sysctl_seq_if;
    logic       user_sw1_n;
    logic       user_sw2_n;
    logic       rst_sys;
    logic       rst_cfg_reload;
    logic       led_pwronblink;
    logic [1:0] seq_state;

    // master: board/pin side, drives the raw buttons and consumes the resets
    modport master (
        output user_sw1_n,
        output user_sw2_n,
        input  rst_sys,
        input  rst_cfg_reload,
        input  led_pwronblink,
        input  seq_state
    );

    modport slave (
        input  user_sw1_n,
        input  user_sw2_n,
        output rst_sys,
        output rst_cfg_reload,
        output led_pwronblink,
        output seq_state
    );
endinterface
`default_nettype wire

// File: rtl/pcileech_sysctl_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pcileech_sysctl_seq : button conditioning, fabric reset and reload sequencer.
// Define PCILEECH_SYSCTL_DEBOUNCE_EN to build the button debounce filter. Rev 1.0
// ----------------------------------------------------------------------------
module pcileech_sysctl_seq #(
    parameter int unsigned PARAM_RST_CYCLES      = 64,
    parameter int unsigned PARAM_RELOAD_CYCLES   = 500000000,
    parameter int unsigned PARAM_DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PARAM_BLINK_BIT       = 24
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pcileech_sysctl_seq_if.slave  sys
);
    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_RUN    = 2'd1,
        S_HOLD   = 2'd2,
        S_RELOAD = 2'd3
    } state_t;

    localparam logic [7:0]  c_RST_LAST    = 8'(PARAM_RST_CYCLES - 1);
    localparam logic [31:0] c_RELOAD_LAST = 32'(PARAM_RELOAD_CYCLES - 1);

    if (PARAM_RST_CYCLES < 1 || PARAM_RST_CYCLES > 256) begin : g_chk_rst
        $error("PARAM_RST_CYCLES must be in 1..256");
    end
    if (PARAM_RELOAD_CYCLES < 1) begin : g_chk_reload
        $error("PARAM_RELOAD_CYCLES must be at least 1");
    end
    if (PARAM_DEBOUNCE_CYCLES < 1) begin : g_chk_deb
        $error("PARAM_DEBOUNCE_CYCLES must be at least 1");
    end
    if (PARAM_BLINK_BIT + 3 > 63) begin : g_chk_blink
        $error("PARAM_BLINK_BIT must leave room for the 8-period window");
    end

    // bit 0 = button 1, bit 1 = button 2
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] sw_f;

    always_comb begin
        sync1_d = {sys.user_sw2_n, sys.user_sw1_n};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef PCILEECH_SYSCTL_DEBOUNCE_EN
    localparam int unsigned c_DEB_W = (PARAM_DEBOUNCE_CYCLES > 1) ? $clog2(PARAM_DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(PARAM_DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [c_DEB_W-1:0] cnt_q, cnt_d;
        logic               f_q, f_d;

        // counts consecutive disagreeing cycles; any agreeing cycle restarts it
        always_comb begin
            cnt_d = '0;
            f_d   = f_q;
            if (sync2_q[i] != f_q) begin
                if (cnt_q == c_DEB_LAST) begin
                    f_d = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                f_q   <= 1'b1;
            end else begin
                cnt_q <= cnt_d;
                f_q   <= f_d;
            end
        end

        assign sw_f[i] = f_q;
    end
`else
    assign sw_f = sync2_q;
`endif

    state_t      state_q, state_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [31:0] press_cnt_q, press_cnt_d;
    logic [63:0] uptime_q, uptime_d;
    logic        rst_sys_q, rst_sys_d;
    logic        rst_cfg_reload_q, rst_cfg_reload_d;
    logic        led_pwronblink_q, led_pwronblink_d;
    logic [1:0]  seq_state_q, seq_state_d;
    logic        blink;

    always_comb begin
        state_d = state_q;
        // release is tested before the threshold so it always wins over reload
        case (state_q)
            S_RESET: begin
                if (!sw_f[1])                    state_d = S_HOLD;
                else if (rst_cnt_q == c_RST_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (!sw_f[1]) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (sw_f[1])                           state_d = S_RESET;
                else if (press_cnt_q == c_RELOAD_LAST) state_d = S_RELOAD;
            end
            S_RELOAD: begin
                if (sw_f[1]) state_d = S_RESET;
            end
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        rst_cnt_d   = rst_cnt_q;
        press_cnt_d = press_cnt_q;
        uptime_d    = uptime_q + 64'd1;

        if (state_d == S_RESET && state_q != S_RESET) begin
            rst_cnt_d = '0;
            uptime_d  = '0;
        end else if (state_q == S_RESET) begin
            rst_cnt_d = rst_cnt_q + 8'd1;
        end

        if (state_d == S_HOLD && state_q != S_HOLD) begin
            press_cnt_d = '0;
        end else if (state_q == S_HOLD) begin
            press_cnt_d = press_cnt_q + 32'd1;
        end
    end

    always_comb begin
        blink            = uptime_q[PARAM_BLINK_BIT] & (uptime_q[63:PARAM_BLINK_BIT+3] == '0);
        rst_sys_d        = (state_q != S_RUN);
        rst_cfg_reload_d = (state_q == S_RELOAD);
        led_pwronblink_d = ~sw_f[0] ^ blink;
        seq_state_d      = state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_RESET;
            rst_cnt_q        <= '0;
            press_cnt_q      <= '0;
            uptime_q         <= '0;
            rst_sys_q        <= 1'b1;
            rst_cfg_reload_q <= 1'b0;
            led_pwronblink_q <= 1'b0;
            seq_state_q      <= 2'd0;
        end else begin
            state_q          <= state_d;
            rst_cnt_q        <= rst_cnt_d;
            press_cnt_q      <= press_cnt_d;
            uptime_q         <= uptime_d;
            rst_sys_q        <= rst_sys_d;
            rst_cfg_reload_q <= rst_cfg_reload_d;
            led_pwronblink_q <= led_pwronblink_d;
            seq_state_q      <= seq_state_d;
        end
    end

    assign sys.rst_sys        = rst_sys_q;
    assign sys.rst_cfg_reload = rst_cfg_reload_q;
    assign sys.led_pwronblink = led_pwronblink_q;
    assign sys.seq_state      = seq_state_q;

endmodule
`default_nettype wire

// File: tb/tb_pcileech_sysctl_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pcileech_sysctl_seq : randomized bench for pcileech_sysctl_seq. Rev 1.0
// ----------------------------------------------------------------------------
module tb_pcileech_sysctl_seq;
    localparam int RST_N   = 4;
    localparam int REL_N   = 20;
    localparam int DEB_N   = 3;
    localparam int BLINK_B = 2;
`ifdef PCILEECH_SYSCTL_DEBOUNCE_EN
    localparam bit DEB_ON  = 1'b1;
    localparam int DEB_LAT = DEB_N;
`else
    localparam bit DEB_ON  = 1'b0;
    localparam int DEB_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pcileech_sysctl_seq_if sys();

    pcileech_sysctl_seq #(
        .PARAM_RST_CYCLES      (RST_N),
        .PARAM_RELOAD_CYCLES   (REL_N),
        .PARAM_DEBOUNCE_CYCLES (DEB_N),
        .PARAM_BLINK_BIT       (BLINK_B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sys (sys)
    );

    wire [4:0] w_obs = {sys.rst_sys, sys.rst_cfg_reload, sys.led_pwronblink, sys.seq_state};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase + time-in-phase, uptime, and pin histories
    int              m_state;
    int              m_t;
    longint unsigned m_up;
    bit              m_f1, m_f2;
    bit [31:0]       m_h1, m_h2;     // bit0 = most recent pin sample
    logic [4:0]      m_exp;

    task automatic model_reset();
        m_state = 0;
        m_t     = 0;
        m_up    = 0;
        m_f1    = 1'b1;
        m_f2    = 1'b1;
        m_h1    = '1;
        m_h2    = '1;
        m_exp   = 5'b10000;
    endtask

    function automatic bit blink(longint unsigned up);
        return (((up >> BLINK_B) & 64'd1) == 64'd1) && (up < (64'd1 << (BLINK_B + 3)));
    endfunction

    // true when each of the last DEB_N synchronized samples disagrees with f
    function automatic bit settles(bit f, bit [31:0] h);
        for (int j = 1; j <= DEB_N; j++) begin
            if (h[j] == f) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic tick();
        bit f1, f2;
        int nxt;
        f1 = DEB_ON ? m_f1 : m_h1[1];
        f2 = DEB_ON ? m_f2 : m_h2[1];
        m_exp = {(m_state != 1), (m_state == 3), (~f1 ^ blink(m_up)), 2'(m_state)};
        nxt = m_state;
        case (m_state)
            0:       if (!f2) nxt = 2; else if (m_t == RST_N - 1) nxt = 1;
            1:       if (!f2) nxt = 2;
            2:       if (f2) nxt = 0; else if (m_t == REL_N - 1) nxt = 3;
            default: if (f2) nxt = 0;
        endcase
        m_up    = (nxt == 0 && m_state != 0) ? 64'd0 : m_up + 64'd1;
        m_t     = (nxt != m_state) ? 0 : m_t + 1;
        m_state = nxt;
        if (DEB_ON) begin
            if (settles(m_f1, m_h1)) m_f1 = ~m_f1;
            if (settles(m_f2, m_h2)) m_f2 = ~m_f2;
        end
        m_h1 = {m_h1[30:0], sys.user_sw1_n};
        m_h2 = {m_h2[30:0], sys.user_sw2_n};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int first_low;
        int reload_hi;
        sys.user_sw1_n = 1'b1;
        sys.user_sw2_n = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (w_obs !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_values obs=%b exp=%b", w_obs, 5'b10000);
        end
        model_reset();
        rst = 1'b0;
        first_low = -1;
        reload_hi = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            vectors++;
            if (w_obs !== m_exp) begin
                miscompares++;
                $display("FAIL reset_seq tick=%0d obs=%b exp=%b", i, w_obs, m_exp);
            end
            if (first_low < 0 && sys.rst_sys === 1'b0) first_low = i;
            if (sys.rst_cfg_reload === 1'b1) reload_hi++;
        end
        vectors++;
        if (first_low != RST_N + 1) begin
            miscompares++;
            $display("FAIL reset_len obs=%0d exp=%0d", first_low, RST_N + 1);
        end
        vectors++;
        if (sys.seq_state !== 2'd1 || reload_hi != 0) begin
            miscompares++;
            $display("FAIL reset_end state=%0d reload_hi=%0d exp state=1 reload_hi=0", sys.seq_state, reload_hi);
        end
    endtask

    task automatic test_short_press();
        int rise;
        int n_reset;
        int reload_hi;
        sys.user_sw2_n = 1'b0;
        tick();
        tick();
        sys.user_sw2_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (w_obs !== m_exp) begin
                miscompares++;
                $display("FAIL glitch2 tick=%0d obs=%b exp=%b", i, w_obs, m_exp);
            end
        end
        rise = -1;
        n_reset = 0;
        reload_hi = 0;
        for (int i = 1; i <= 35; i++) begin
            sys.user_sw2_n = (i <= 10) ? 1'b0 : 1'b1;
            tick();
            vectors++;
            if (w_obs !== m_exp) begin
                miscompares++;
                $display("FAIL press10 tick=%0d obs=%b exp=%b", i, w_obs, m_exp);
            end
            if (rise < 0 && sys.rst_sys === 1'b1) rise = i;
            if (sys.seq_state === 2'd0) n_reset++;
            if (sys.rst_cfg_reload === 1'b1) reload_hi++;
        end
        vectors++;
        if (rise != 2 + DEB_LAT + 2) begin
            miscompares++;
            $display("FAIL press_latency obs=%0d exp=%0d", rise, 2 + DEB_LAT + 2);
        end
        vectors++;
        if (n_reset != RST_N || reload_hi != 0 || sys.seq_state !== 2'd1) begin
            miscompares++;
            $display("FAIL press_recover reset_ticks=%0d reload_hi=%0d state=%0d exp %0d/0/1",
                     n_reset, reload_hi, sys.seq_state, RST_N);
        end
    endtask

    task automatic test_reload();
        int rise;
        int reload_hi;
        int n_reset;
        rise = -1;
        reload_hi = 0;
        n_reset = 0;
        for (int i = 1; i <= 75; i++) begin
            sys.user_sw2_n = (i <= 40) ? 1'b0 : 1'b1;
            tick();
            vectors++;
            if (w_obs !== m_exp) begin
                miscompares++;
                $display("FAIL reload tick=%0d obs=%b exp=%b", i, w_obs, m_exp);
            end
            if (rise < 0 && sys.rst_cfg_reload === 1'b1) rise = i;
            if (sys.rst_cfg_reload === 1'b1) reload_hi++;
            if (i > 40 && sys.seq_state === 2'd0) n_reset++;
        end
        vectors++;
        if (rise != 2 + DEB_LAT + 1 + REL_N + 1) begin
            miscompares++;
            $display("FAIL reload_rise obs=%0d exp=%0d", rise, 2 + DEB_LAT + 1 + REL_N + 1);
        end
        vectors++;
        if (reload_hi != 40 - REL_N || n_reset != RST_N) begin
            miscompares++;
            $display("FAIL reload_len high=%0d reset_ticks=%0d exp %0d/%0d", reload_hi, n_reset, 40 - REL_N, RST_N);
        end
    endtask

    task automatic test_release_at_threshold();
        int reload_hi;
        int hold_ticks;
        reload_hi = 0;
        hold_ticks = 0;
        for (int i = 1; i <= 40; i++) begin
            sys.user_sw2_n = (i <= 20) ? 1'b0 : 1'b1;
            tick();
            vectors++;
            if (w_obs !== m_exp) begin
                miscompares++;
                $display("FAIL thresh tick=%0d obs=%b exp=%b", i, w_obs, m_exp);
            end
            if (sys.rst_cfg_reload === 1'b1) reload_hi++;
            if (sys.seq_state === 2'd2) hold_ticks++;
        end
        vectors++;
        if (reload_hi != 0 || hold_ticks != REL_N || sys.seq_state !== 2'd1) begin
            miscompares++;
            $display("FAIL release_wins reload_hi=%0d hold=%0d state=%0d exp 0/%0d/1",
                     reload_hi, hold_ticks, sys.seq_state, REL_N);
        end
    endtask

    task automatic test_async_reset();
        int first_low;
        sys.user_sw2_n = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (w_obs !== 5'b10000) begin
            miscompares++;
            $display("FAIL async_reset obs=%b exp=%b", w_obs, 5'b10000);
        end
        sys.user_sw2_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        first_low = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            vectors++;
            if (w_obs !== m_exp) begin
                miscompares++;
                $display("FAIL post_reset tick=%0d obs=%b exp=%b", i, w_obs, m_exp);
            end
            if (first_low < 0 && sys.rst_sys === 1'b0) first_low = i;
        end
        vectors++;
        if (first_low != RST_N + 1) begin
            miscompares++;
            $display("FAIL post_reset_len obs=%0d exp=%0d", first_low, RST_N + 1);
        end
    endtask

    task automatic test_glitch_1cyc();
        int high;
        high = 0;
        sys.user_sw2_n = 1'b0;
        tick();
        sys.user_sw2_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (w_obs !== m_exp) begin
                miscompares++;
                $display("FAIL glitch1 tick=%0d obs=%b exp=%b", i, w_obs, m_exp);
            end
            if (sys.rst_sys === 1'b1) high++;
        end
        vectors++;
        if (high != (DEB_ON ? 0 : RST_N + 1)) begin
            miscompares++;
            $display("FAIL glitch1_len obs=%0d exp=%0d", high, DEB_ON ? 0 : RST_N + 1);
        end
    endtask

    task automatic test_random();
        int len;
        int gap;
        for (int it = 0; it < 20; it++) begin
            len = $urandom_range(1, 30);
            gap = $urandom_range(15, 40);
            for (int i = 0; i < len + gap; i++) begin
                sys.user_sw2_n = (i < len) ? 1'b0 : 1'b1;
                if ($urandom_range(0, 7) == 0) sys.user_sw1_n = ~sys.user_sw1_n;
                tick();
                vectors++;
                if (w_obs !== m_exp) begin
                    miscompares++;
                    $display("FAIL random it=%0d i=%0d obs=%b exp=%b", it, i, w_obs, m_exp);
                end
            end
        end
        sys.user_sw1_n = 1'b1;
    endtask

    initial begin
        sys.user_sw1_n = 1'b1;
        sys.user_sw2_n = 1'b1;
        model_reset();
        test_reset();
        test_short_press();
        test_reload();
        test_release_at_threshold();
        test_async_reset();
        test_glitch_1cyc();
        test_random();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
